// File: rtl/hazard_scoreboard.sv
// Decode-side hazard unit: M/W forwarding selects, load-use and scoreboard stalls,
// and a latency-counter FSM for a single multi-cycle (divider class) unit.
module hazard_scoreboard #(
  parameter int NRP          = 2,
  parameter int AW           = 5,
  parameter int MC_LAT       = 33,
  parameter int M_LOAD_STALL = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_d_valid,
  input  logic [NRP*AW-1:0] i_d_raddr,
  input  logic [NRP-1:0]    i_d_ren,
  input  logic              i_d_mc,
  input  logic              i_e_valid,
  input  logic              i_m_valid,
  input  logic              i_w_valid,
  input  logic [AW-1:0]     i_e_waddr,
  input  logic [AW-1:0]     i_m_waddr,
  input  logic [AW-1:0]     i_w_waddr,
  input  logic              i_e_regen,
  input  logic              i_m_regen,
  input  logic              i_w_regen,
  input  logic              i_e_load,
  input  logic              i_m_load,
  input  logic              i_mc_issue,
  input  logic [AW-1:0]     i_mc_waddr,
  input  logic              i_mc_abort,
  output logic [2*NRP-1:0]  o_fwd_sel,
  output logic              o_stall,
  output logic              o_mc_busy,
  output logic              o_mc_done,
  output logic [7:0]        o_mc_cnt
);

  localparam int NREG = 2 ** AW;
  localparam logic [7:0] LP_RELOAD = 8'(MC_LAT - 2);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          r_state, w_state_nxt;
  logic [NREG-1:0] r_pending, w_pending_nxt;
  logic [7:0]      r_mc_cnt, w_mc_cnt_nxt;
  logic [AW-1:0]   r_mc_waddr, w_mc_waddr_nxt;
  logic [AW-1:0]   w_ra;
  logic            w_hazard;
  logic            w_unused_e_regen;

  // A load in E always stalls whether or not it writes back, so E's regen is not needed.
  assign w_unused_e_regen = i_e_regen;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_pending  <= '0;
      r_mc_cnt   <= '0;
      r_mc_waddr <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pending  <= w_pending_nxt;
      r_mc_cnt   <= w_mc_cnt_nxt;
      r_mc_waddr <= w_mc_waddr_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_pending_nxt  = r_pending;
    w_mc_cnt_nxt   = r_mc_cnt;
    w_mc_waddr_nxt = r_mc_waddr;
    if (i_mc_abort) begin
      w_state_nxt   = IDLE;
      w_pending_nxt = '0;
      w_mc_cnt_nxt  = '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (i_mc_issue) begin
            w_state_nxt    = BUSY;
            w_mc_cnt_nxt   = LP_RELOAD;
            w_mc_waddr_nxt = i_mc_waddr;
            if (i_mc_waddr != '0) w_pending_nxt[i_mc_waddr] = 1'b1;
          end
        end
        BUSY: begin
          if (r_mc_cnt != 8'd0) w_mc_cnt_nxt = r_mc_cnt - 8'd1;
          else                  w_state_nxt  = DONE;
        end
        DONE: begin
          // Old bit is cleared first so a same-address back-to-back issue keeps it set.
          w_pending_nxt[r_mc_waddr] = 1'b0;
          w_state_nxt = IDLE;
          if (i_mc_issue) begin
            w_state_nxt    = BUSY;
            w_mc_cnt_nxt   = LP_RELOAD;
            w_mc_waddr_nxt = i_mc_waddr;
            if (i_mc_waddr != '0) w_pending_nxt[i_mc_waddr] = 1'b1;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    o_fwd_sel = '0;
    w_hazard  = 1'b0;
    w_ra      = '0;
    for (int i = 0; i < NRP; i++) begin
      w_ra = i_d_raddr[i*AW +: AW];
      if (w_ra != '0 && w_ra == i_m_waddr && i_m_regen && i_m_valid)
        o_fwd_sel[2*i +: 2] = 2'b01;
      else if (w_ra != '0 && w_ra == i_w_waddr && i_w_regen && i_w_valid)
        o_fwd_sel[2*i +: 2] = 2'b10;
      if (i_d_ren[i] && w_ra != '0) begin
        if (w_ra == i_e_waddr && i_e_load && i_e_valid) w_hazard = 1'b1;
        if ((M_LOAD_STALL != 0) && w_ra == i_m_waddr && i_m_load && i_m_valid) w_hazard = 1'b1;
        if (r_pending[w_ra]) w_hazard = 1'b1;
      end
    end
    o_stall = i_d_valid && (w_hazard || (i_d_mc && r_state != IDLE));
  end

  assign o_mc_busy = (r_state != IDLE);
  assign o_mc_done = (r_state == DONE);
  assign o_mc_cnt  = r_mc_cnt;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: vector table, directed multi-cycle
// sequences and a randomized run against a time-based reference model.
module tb_hazard_scoreboard;

  localparam int NRP    = 2;
  localparam int AW     = 5;
  localparam int MC_LAT = 33;

  logic       clk = 1'b0;
  logic       reset;
  logic       i_d_valid;
  logic [9:0] i_d_raddr;
  logic [1:0] i_d_ren;
  logic       i_d_mc;
  logic       i_e_valid, i_m_valid, i_w_valid;
  logic [4:0] i_e_waddr, i_m_waddr, i_w_waddr;
  logic       i_e_regen, i_m_regen, i_w_regen;
  logic       i_e_load, i_m_load;
  logic       i_mc_issue;
  logic [4:0] i_mc_waddr;
  logic       i_mc_abort;
  logic [3:0] o_fwd_sel;
  logic       o_stall, o_mc_busy, o_mc_done;
  logic [7:0] o_mc_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Model: the in-flight op is described only by its age since issue and its target.
  bit         mdl_active = 1'b0;
  int         mdl_age    = 0;
  logic [4:0] mdl_addr   = '0;

  typedef struct {
    string      name;
    logic       dv;
    logic [4:0] ra0, ra1;
    logic [1:0] ren;
    logic       ev;  logic [4:0] ew; logic el;
    logic       mv;  logic [4:0] mw; logic mr; logic ml;
    logic       wv;  logic [4:0] ww; logic wr;
    logic [3:0] efwd;
    logic       estall;
  } vec_t;

  vec_t vecs[$];

  hazard_scoreboard #(.NRP(NRP), .AW(AW), .MC_LAT(MC_LAT), .M_LOAD_STALL(1)) dut (
    .clk(clk), .reset(reset),
    .i_d_valid(i_d_valid), .i_d_raddr(i_d_raddr), .i_d_ren(i_d_ren), .i_d_mc(i_d_mc),
    .i_e_valid(i_e_valid), .i_m_valid(i_m_valid), .i_w_valid(i_w_valid),
    .i_e_waddr(i_e_waddr), .i_m_waddr(i_m_waddr), .i_w_waddr(i_w_waddr),
    .i_e_regen(i_e_regen), .i_m_regen(i_m_regen), .i_w_regen(i_w_regen),
    .i_e_load(i_e_load), .i_m_load(i_m_load),
    .i_mc_issue(i_mc_issue), .i_mc_waddr(i_mc_waddr), .i_mc_abort(i_mc_abort),
    .o_fwd_sel(o_fwd_sel), .o_stall(o_stall), .o_mc_busy(o_mc_busy),
    .o_mc_done(o_mc_done), .o_mc_cnt(o_mc_cnt)
  );

  always #5 clk = ~clk;

  function automatic vec_t mkVec(string name, logic dv, logic [4:0] ra0, logic [4:0] ra1,
                                 logic [1:0] ren, logic ev, logic [4:0] ew, logic el,
                                 logic mv, logic [4:0] mw, logic mr, logic ml,
                                 logic wv, logic [4:0] ww, logic wr,
                                 logic [3:0] efwd, logic estall);
    vec_t v;
    v.name = name; v.dv = dv; v.ra0 = ra0; v.ra1 = ra1; v.ren = ren;
    v.ev = ev; v.ew = ew; v.el = el;
    v.mv = mv; v.mw = mw; v.mr = mr; v.ml = ml;
    v.wv = wv; v.ww = ww; v.wr = wr;
    v.efwd = efwd; v.estall = estall;
    return v;
  endfunction

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic clearInputs();
    i_d_valid = 0; i_d_raddr = '0; i_d_ren = '0; i_d_mc = 0;
    i_e_valid = 0; i_m_valid = 0; i_w_valid = 0;
    i_e_waddr = '0; i_m_waddr = '0; i_w_waddr = '0;
    i_e_regen = 0; i_m_regen = 0; i_w_regen = 0;
    i_e_load = 0; i_m_load = 0;
    i_mc_issue = 0; i_mc_waddr = '0; i_mc_abort = 0;
  endtask

  task automatic applyStimulus(vec_t v);
    i_d_valid = v.dv; i_d_raddr = {v.ra1, v.ra0}; i_d_ren = v.ren; i_d_mc = 0;
    i_e_valid = v.ev; i_e_waddr = v.ew; i_e_load = v.el; i_e_regen = 1'b1;
    i_m_valid = v.mv; i_m_waddr = v.mw; i_m_regen = v.mr; i_m_load = v.ml;
    i_w_valid = v.wv; i_w_waddr = v.ww; i_w_regen = v.wr;
    i_mc_issue = 0; i_mc_waddr = '0; i_mc_abort = 0;
  endtask

  task automatic applyRandom();
    i_d_valid  = ($urandom_range(0, 7) != 0);
    i_d_raddr  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
    i_d_ren    = 2'($urandom_range(0, 3));
    i_d_mc     = ($urandom_range(0, 3) == 0);
    i_e_valid  = 1'($urandom); i_m_valid = 1'($urandom); i_w_valid = 1'($urandom);
    i_e_waddr  = 5'($urandom_range(0, 7));
    i_m_waddr  = 5'($urandom_range(0, 7));
    i_w_waddr  = 5'($urandom_range(0, 7));
    i_e_regen  = 1'($urandom); i_m_regen = 1'($urandom); i_w_regen = 1'($urandom);
    i_e_load   = ($urandom_range(0, 3) == 0);
    i_m_load   = ($urandom_range(0, 3) == 0);
    i_mc_issue = ($urandom_range(0, 7) == 0);
    i_mc_waddr = 5'($urandom_range(0, 7));
    i_mc_abort = ($urandom_range(0, 99) == 0);
    reset      = ($urandom_range(0, 299) != 0);
  endtask

  // Compare every output with the model for the current cycle, then advance one clock.
  task automatic runCycle();
    logic [3:0] ef;
    logic       es;
    logic [4:0] ra;
    int         ecnt;
    #1;
    ef = '0;
    es = 1'b0;
    for (int p = 0; p < NRP; p++) begin
      ra = (p == 0) ? i_d_raddr[4:0] : i_d_raddr[9:5];
      if (ra != 0 && ra == i_m_waddr && i_m_regen && i_m_valid) ef[2*p +: 2] = 2'b01;
      else if (ra != 0 && ra == i_w_waddr && i_w_regen && i_w_valid) ef[2*p +: 2] = 2'b10;
      if (i_d_valid && i_d_ren[p] && ra != 0) begin
        if (ra == i_e_waddr && i_e_load && i_e_valid) es = 1'b1;
        if (ra == i_m_waddr && i_m_load && i_m_valid) es = 1'b1;
        if (mdl_active && ra == mdl_addr) es = 1'b1;
      end
    end
    if (i_d_valid && i_d_mc && mdl_active) es = 1'b1;
    ecnt = (mdl_active && mdl_age < MC_LAT) ? (MC_LAT - 1 - mdl_age) : 0;
    checkOutput("fwd_sel", 32'(o_fwd_sel), 32'(ef));
    checkOutput("stall", 32'(o_stall), 32'(es));
    checkOutput("mc_busy", 32'(o_mc_busy), 32'(mdl_active));
    checkOutput("mc_done", 32'(o_mc_done), 32'(mdl_active && mdl_age == MC_LAT));
    checkOutput("mc_cnt", 32'(o_mc_cnt), 32'(ecnt));
    if (!reset || i_mc_abort) begin
      mdl_active = 1'b0;
    end else if (i_mc_issue && (!mdl_active || mdl_age == MC_LAT)) begin
      mdl_active = 1'b1;
      mdl_age    = 1;
      mdl_addr   = i_mc_waddr;
    end else if (mdl_active) begin
      if (mdl_age == MC_LAT) mdl_active = 1'b0;
      else                   mdl_age++;
    end
    @(negedge clk);
  endtask

  initial begin
    int done_seen;
    clearInputs();
    reset = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("reset_busy", 32'(o_mc_busy), 32'd0);
    checkOutput("reset_done", 32'(o_mc_done), 32'd0);
    checkOutput("reset_cnt", 32'(o_mc_cnt), 32'd0);
    runCycle();
    reset = 1'b1;
    runCycle();

    vecs.push_back(mkVec("fwd_m_prio", 1, 5, 0, 2'b11, 0, 0, 0, 1, 5, 1, 0, 1, 5, 1, 4'b0001, 0));
    vecs.push_back(mkVec("fwd_w_only", 1, 5, 0, 2'b11, 0, 0, 0, 0, 5, 1, 0, 1, 5, 1, 4'b0010, 0));
    vecs.push_back(mkVec("fwd_r0", 1, 0, 0, 2'b11, 0, 0, 0, 1, 5, 1, 0, 1, 5, 1, 4'b0000, 0));
    vecs.push_back(mkVec("load_e", 1, 0, 8, 2'b10, 1, 8, 1, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 1));
    vecs.push_back(mkVec("load_e_noren", 1, 0, 8, 2'b00, 1, 8, 1, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0));
    vecs.push_back(mkVec("load_e_nodv", 0, 0, 8, 2'b10, 1, 8, 1, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0));
    vecs.push_back(mkVec("load_e_p0_dis", 1, 8, 0, 2'b10, 1, 8, 1, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0));
    vecs.push_back(mkVec("load_m", 1, 9, 0, 2'b01, 0, 0, 0, 1, 9, 1, 1, 0, 0, 0, 4'b0001, 1));
    vecs.push_back(mkVec("fwd_w_p1", 1, 0, 7, 2'b11, 0, 0, 0, 0, 0, 0, 0, 1, 7, 1, 4'b1000, 0));
    vecs.push_back(mkVec("fwd_both_m", 1, 5, 5, 2'b11, 0, 0, 0, 1, 5, 1, 0, 0, 0, 0, 4'b0101, 0));
    vecs.push_back(mkVec("load_e_inval", 1, 8, 0, 2'b01, 0, 8, 1, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0));
    vecs.push_back(mkVec("m_noregen", 1, 5, 0, 2'b11, 0, 0, 0, 1, 5, 0, 0, 1, 5, 1, 4'b0010, 0));
    vecs.push_back(mkVec("load_e_r0", 1, 0, 0, 2'b11, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0));
    for (int k = 0; k < vecs.size(); k++) begin
      applyStimulus(vecs[k]);
      #1;
      checkOutput({vecs[k].name, "_fwd"}, 32'(o_fwd_sel), 32'(vecs[k].efwd));
      checkOutput({vecs[k].name, "_stall"}, 32'(o_stall), 32'(vecs[k].estall));
      runCycle();
    end

    // Issue to r3, back-to-back issue to r4 in the DONE cycle.
    clearInputs();
    i_d_valid = 1; i_d_raddr = {5'd0, 5'd3}; i_d_ren = 2'b01;
    i_mc_issue = 1; i_mc_waddr = 5'd3;
    runCycle();
    i_mc_issue = 0;
    for (int k = 1; k <= MC_LAT; k++) begin
      if (k == MC_LAT) begin i_mc_issue = 1; i_mc_waddr = 5'd4; end
      #1;
      checkOutput("mc1_busy", 32'(o_mc_busy), 32'd1);
      checkOutput("mc1_done", 32'(o_mc_done), 32'(k == MC_LAT));
      checkOutput("mc1_stall_r3", 32'(o_stall), 32'd1);
      runCycle();
    end
    i_mc_issue = 0;
    #1;
    checkOutput("b2b_r3_released", 32'(o_stall), 32'd0);
    i_d_raddr = {5'd0, 5'd4};
    #1;
    checkOutput("b2b_r4_pending", 32'(o_stall), 32'd1);
    runCycle();
    for (int k = MC_LAT + 2; k <= 2 * MC_LAT + 1; k++) begin
      #1;
      checkOutput("mc2_done", 32'(o_mc_done), 32'(k == 2 * MC_LAT));
      runCycle();
    end
    #1;
    checkOutput("mc2_idle", 32'(o_mc_busy), 32'd0);

    // Abort mid-BUSY, with a competing issue in the same cycle.
    clearInputs();
    i_d_valid = 1; i_d_raddr = {5'd0, 5'd3}; i_d_ren = 2'b01;
    i_mc_issue = 1; i_mc_waddr = 5'd3;
    runCycle();
    i_mc_issue = 0;
    for (int k = 1; k < 10; k++) runCycle();
    i_mc_abort = 1; i_mc_issue = 1; i_mc_waddr = 5'd6;
    runCycle();
    i_mc_abort = 0; i_mc_issue = 0;
    #1;
    checkOutput("abort_busy", 32'(o_mc_busy), 32'd0);
    checkOutput("abort_cnt", 32'(o_mc_cnt), 32'd0);
    checkOutput("abort_stall_r3", 32'(o_stall), 32'd0);
    done_seen = 0;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (o_mc_done) done_seen++;
      runCycle();
    end
    checkOutput("abort_no_done", 32'(done_seen), 32'd0);

    // Structural stall, then a one-cycle reset while BUSY.
    clearInputs();
    i_d_valid = 1; i_d_raddr = {5'd0, 5'd9}; i_d_ren = 2'b01;
    i_mc_issue = 1; i_mc_waddr = 5'd2;
    runCycle();
    i_mc_issue = 0;
    for (int k = 1; k < 5; k++) runCycle();
    i_d_mc = 1;
    #1;
    checkOutput("struct_stall", 32'(o_stall), 32'd1);
    runCycle();
    reset = 1'b0;
    runCycle();
    reset = 1'b1;
    i_d_raddr = {5'd0, 5'd2};
    #1;
    checkOutput("rst_busy", 32'(o_mc_busy), 32'd0);
    checkOutput("rst_done", 32'(o_mc_done), 32'd0);
    checkOutput("rst_stall", 32'(o_stall), 32'd0);
    runCycle();

    for (int k = 0; k < 4000; k++) begin
      applyRandom();
      runCycle();
    end
    reset = 1'b1;
    clearInputs();
    runCycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
